regfile_writeback: RTL



---
 rtl/rv32e_pkg.sv | 24 ++
 rtl/load_extend.sv | 30 +++
 rtl/regfile_writeback.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rv32e_pkg.sv
// Shared constants and types for the RV32E register-file writeback path.
package rv32e_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      STROBE,
      RELEASE
   } wb_state_t;

   typedef struct packed {
      logic [3:0]      rd;
      logic [XLEN-1:0] value;
   } wb_entry_t;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of an aligned load word and sign/zero-extends it.
module load_extend
   import rv32e_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] data,
   output logic [31:0] value,
   output logic        invalid
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'(data >> {addr_lo, 3'b000});
      half_sel = 16'(data >> {addr_lo[1], 4'b0000});
      value    = '0;
      invalid  = 1'b0;
      case (funct3)
         LB:      value = {{24{byte_sel[7]}}, byte_sel};
         LH:      value = {{16{half_sel[15]}}, half_sel};
         LW:      value = data;
         LBU:     value = {24'd0, byte_sel};
         LHU:     value = {16'd0, half_sel};
         default: invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/regfile_writeback.sv
// Buffers ALU/load results and writes them into the register file with a setup/strobe/release sequence.
// Define WB_BYPASS_EN to add the fwd_sel/fwd_hit/fwd_value forwarding port.
module regfile_writeback
   import rv32e_pkg::*;
#(
   parameter int size  = XLEN,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [3:0]      alu_rd,
   input  logic [size-1:0] alu_value,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [3:0]      ld_rd,
   input  logic [31:0]     ld_data,
   input  logic [2:0]      ld_funct3,
   input  logic [1:0]      ld_addr_lo,
   output logic            ld_err,
   output logic [3:0]      write_register,
   output logic [size-1:0] write_value,
   output logic            wr_en,
   output logic [15:0]     pending_mask,
   output logic            busy
`ifdef WB_BYPASS_EN
   ,
   input  logic [3:0]      fwd_sel,
   output logic            fwd_hit,
   output logic [size-1:0] fwd_value
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_state_t        state_q, state_d;
   logic [3:0]       buf_rd_q  [DEPTH];
   logic [3:0]       buf_rd_d  [DEPTH];
   logic [size-1:0]  buf_val_q [DEPTH];
   logic [size-1:0]  buf_val_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [3:0]       write_register_q, write_register_d;
   logic [size-1:0]  write_value_q, write_value_d;
   logic             ld_err_q, ld_err_d;

   logic [31:0]      ld_value;
   logic             ld_invalid;
   logic             full, ld_take, alu_take, push, pop;
   logic [3:0]       push_rd;
   logic [size-1:0]  push_val;
   logic [PTR_W-1:0] tail;

   load_extend u_load_extend (
      .funct3  (ld_funct3),
      .addr_lo (ld_addr_lo),
      .data    (ld_data),
      .value   (ld_value),
      .invalid (ld_invalid)
   );

   // Loads have priority; rd=0 and bad loads complete the handshake without being buffered.
   always_comb begin
      full      = (count_q == CNT_W'(DEPTH));
      ld_ready  = !full;
      alu_ready = !full && !ld_valid;
      ld_take   = ld_valid && ld_ready;
      alu_take  = alu_valid && alu_ready;
      push      = 1'b0;
      push_rd   = '0;
      push_val  = '0;
      ld_err_d  = ld_take && ld_invalid;
      if (ld_take) begin
         push     = !ld_invalid && (ld_rd != '0);
         push_rd  = ld_rd;
         push_val = size'(ld_value);
      end else if (alu_take) begin
         push     = (alu_rd != '0);
         push_rd  = alu_rd;
         push_val = alu_value;
      end
   end

   always_comb begin
      state_d          = state_q;
      pop              = 1'b0;
      write_register_d = write_register_q;
      write_value_d    = write_value_q;
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               state_d = SETUP;
               pop     = 1'b1;
            end
         end
         SETUP:  state_d = STROBE;
         STROBE: state_d = RELEASE;
         RELEASE: begin
            if (count_q != '0) begin
               state_d = SETUP;
               pop     = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (pop) begin
         write_register_d = buf_rd_q[head_q];
         write_value_d    = buf_val_q[head_q];
      end
   end

   always_comb begin
      buf_rd_d  = buf_rd_q;
      buf_val_d = buf_val_q;
      tail      = head_q + count_q[PTR_W-1:0];
      if (push) begin
         buf_rd_d[tail]  = push_rd;
         buf_val_d[tail] = push_val;
      end
      head_d  = pop ? head_q + PTR_W'(1) : head_q;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // The in-flight write stays pending through RELEASE, the cycle the register file captures it.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx          = '0;
      pending_mask = '0;
      if (state_q != IDLE) pending_mask[write_register_q] = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PTR_W'(i);
         if (CNT_W'(i) < count_q) pending_mask[buf_rd_q[idx]] = 1'b1;
      end
   end

`ifdef WB_BYPASS_EN
   // Scan oldest to youngest so the last match wins.
   always_comb begin
      logic [PTR_W-1:0] fidx;
      fidx      = '0;
      fwd_hit   = 1'b0;
      fwd_value = '0;
      if (fwd_sel != '0) begin
         if (state_q != IDLE && write_register_q == fwd_sel) begin
            fwd_hit   = 1'b1;
            fwd_value = write_value_q;
         end
         for (int i = 0; i < DEPTH; i++) begin
            fidx = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q && buf_rd_q[fidx] == fwd_sel) begin
               fwd_hit   = 1'b1;
               fwd_value = buf_val_q[fidx];
            end
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         head_q           <= '0;
         count_q          <= '0;
         write_register_q <= '0;
         write_value_q    <= '0;
         ld_err_q         <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_rd_q[i]  <= '0;
            buf_val_q[i] <= '0;
         end
      end else begin
         state_q          <= state_d;
         head_q           <= head_d;
         count_q          <= count_d;
         write_register_q <= write_register_d;
         write_value_q    <= write_value_d;
         ld_err_q         <= ld_err_d;
         buf_rd_q         <= buf_rd_d;
         buf_val_q        <= buf_val_d;
      end
   end

   assign write_register = write_register_q;
   assign write_value    = write_value_q;
   assign wr_en          = (state_q == STROBE);
   assign ld_err         = ld_err_q;
   assign busy           = (count_q != '0) || (state_q != IDLE);

endmodule
